// File: rtl/axis_buf_pkg.sv
// Shared helpers for the AXI-Stream skid FIFO: counter sizing and depth legality.
package axis_buf_pkg;

   // Width of a counter that must represent 0..depth inclusive.
   function automatic int clog2_cnt(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Storage depth must be a power of two and at least two slots.
   function automatic bit is_pow2_ge2(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/axis_buf_mem.sv
// Beat storage: DEPTH x W register array, one synchronous write port and one
// asynchronous read port. Contents are not reset; the top gates its outputs.
module axis_buf_mem #(
   parameter int W     = 35,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [W-1:0]  i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [W-1:0]  o_rd_data
);

   logic [W-1:0] r_mem [DEPTH];

   // Write the accepted beat into its slot.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_skid_fifo.sv
// First-word-fall-through AXI-Stream buffer with registered s_ready, beat and
// complete-packet occupancy, and a synchronous flush.
//
// Handshake: a beat moves on a rising edge where valid & ready are both high;
// the source holds valid and payload stable until that edge, and ready never
// depends combinationally on valid (s_ready is a flop, m_valid comes from count).
module axis_skid_fifo
   import axis_buf_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int USER_WIDTH = 1,
   parameter  int DEPTH      = 4,
   localparam int CW         = clog2_cnt(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic [USER_WIDTH-1:0] s_user,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [USER_WIDTH-1:0] m_user,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic [CW-1:0]         count,
   output logic [CW-1:0]         pkt_count
);

   typedef struct packed {
      logic                  last;
      logic [USER_WIDTH-1:0] user;
      logic [DATA_WIDTH-1:0] data;
   } axis_beat_t;

   localparam int          BEAT_W  = $bits(axis_beat_t);
   localparam int          AW      = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   generate
      if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
         $error("axis_skid_fifo: DEPTH must be a power of two and >= 2");
      end
   endgenerate

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_pkt_count;
   logic          r_s_ready;

   logic          w_push;
   logic          w_pop;
   logic          w_pkt_in;
   logic          w_pkt_out;
   logic [CW-1:0] w_count_next;
   logic [CW-1:0] w_pkt_next;
   axis_beat_t    w_wr_beat;
   axis_beat_t    w_rd_beat;
   axis_beat_t    w_out_beat;

   assign w_push    = s_valid & r_s_ready;
   assign w_pop     = m_valid & m_ready;
   assign w_pkt_in  = w_push & s_last;
   assign w_pkt_out = w_pop & w_rd_beat.last;
   assign w_wr_beat = '{last: s_last, user: s_user, data: s_data};

   axis_buf_mem #(
      .W     (BEAT_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_push & ~flush),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_wr_beat),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_beat)
   );

   // Next beat and packet occupancy; simultaneous in/out cancel.
   always_comb begin
      w_count_next = r_count;
      w_pkt_next   = r_pkt_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
      case ({w_pkt_in, w_pkt_out})
         2'b10:   w_pkt_next = r_pkt_count + CW'(1);
         2'b01:   w_pkt_next = r_pkt_count - CW'(1);
         default: w_pkt_next = r_pkt_count;
      endcase
   end

   // Pointers, counters and the registered ready; flush overrides any transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_pkt_count <= '0;
         r_s_ready   <= 1'b0;
      end else if (flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_pkt_count <= '0;
         r_s_ready   <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count     <= w_count_next;
         r_pkt_count <= w_pkt_next;
         r_s_ready   <= (w_count_next < DEPTH_C);
      end
   end

   // Head beat is presented only while something is stored, so reset and
   // empty states show zeros regardless of stale array contents.
   assign w_out_beat = m_valid ? w_rd_beat : '0;

   assign m_valid   = (r_count != '0);
   assign m_data    = w_out_beat.data;
   assign m_user    = w_out_beat.user;
   assign m_last    = w_out_beat.last;
   assign s_ready   = r_s_ready;
   assign count     = r_count;
   assign pkt_count = r_pkt_count;

   a_count_le_depth : assert property (@(posedge clk) disable iff (!reset_n) r_count <= DEPTH_C);
   a_pkt_le_count   : assert property (@(posedge clk) disable iff (!reset_n) r_pkt_count <= r_count);

endmodule

// File: tb/tb_axis_skid_fifo.sv
// Directed and scoreboarded checks of axis_skid_fifo at DEPTH=4.
module tb_axis_skid_fifo;

  localparam int DW = 32;
  localparam int UW = 2;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [UW-1:0] s_user;
  logic          s_last;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [UW-1:0] m_user;
  logic          m_last;
  logic          m_ready;
  logic [CW-1:0] count;
  logic [CW-1:0] pkt_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW+UW:0] exp_q[$];

  axis_skid_fifo #(
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .DEPTH      (D)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_user    (s_user),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_user    (m_user),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .count     (count),
    .pkt_count (pkt_count)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = r;
  endtask

  task automatic random_run(input int n);
    logic push, pop;
    int   pk;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      s_user  = UW'($urandom_range(0, 3));
      s_last  = ($urandom_range(0, 3) == 0);
      m_ready = 1'($urandom_range(0, 1));
      push = s_valid && s_ready;
      pop  = m_valid && m_ready;
      if (pop) begin
        if (exp_q.size() == 0) check("rnd_pop_empty", 1, 0);
        else check("rnd_beat", {m_last, m_user, m_data}, exp_q.pop_front());
      end
      if (push) exp_q.push_back({s_last, s_user, s_data});
      cyc();
      pk = 0;
      foreach (exp_q[k]) if (exp_q[k][DW+UW]) pk++;
      check("rnd_count", count, exp_q.size());
      check("rnd_pkt", pkt_count, pk);
      check("rnd_m_valid", m_valid, exp_q.size() != 0);
      check("rnd_s_ready", s_ready, exp_q.size() < D);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    s_user  = '0;
    drive(0, 0, 0, 0);

    // T1 reset and first beat
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_count", count, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_m_data", m_data, 0);
    reset_n = 1'b1;
    #1;
    check("rel_s_ready_pre_edge", s_ready, 0);
    cyc();
    check("rel_s_ready", s_ready, 1);
    s_user = 2'b10;
    drive(1, 32'hA5A5_A5A5, 0, 0);
    cyc();
    check("t1_m_valid", m_valid, 1);
    check("t1_m_data", m_data, 32'hA5A5_A5A5);
    check("t1_m_user", m_user, 2'b10);
    check("t1_count", count, 1);
    s_user = '0;
    drive(0, 0, 0, 1);
    cyc();
    check("t1_empty", m_valid, 0);
    check("t1_m_data_zero", m_data, 0);

    // T2 fill and backpressure
    for (int i = 1; i <= 4; i++) begin
      drive(1, DW'(i), 0, 0);
      cyc();
      if (i == 3) check("t2_ready_at3", s_ready, 1);
    end
    check("t2_count_full", count, 4);
    check("t2_s_ready_full", s_ready, 0);
    drive(1, 5, 0, 0);
    cyc();
    check("t2_held_count", count, 4);
    check("t2_head", m_data, 1);
    drive(1, 5, 0, 1);
    cyc();
    check("t2_ready_after_pop", s_ready, 1);
    check("t2_count_pop1", count, 3);
    check("t2_head2", m_data, 2);
    cyc();
    check("t2_count_pushpop", count, 3);
    check("t2_head3", m_data, 3);
    drive(0, 0, 0, 1);
    cyc();
    check("t2_head4", m_data, 4);
    cyc();
    check("t2_head5", m_data, 5);
    cyc();
    check("t2_drained", count, 0);

    // T3 streaming through wrapping pointers
    for (int i = 0; i < 100; i++) begin
      drive(1, DW'(1000 + i), 0, 1);
      cyc();
      check("t3_valid", m_valid, 1);
      check("t3_data", m_data, 1000 + i);
      check("t3_count", count, 1);
    end
    drive(0, 0, 0, 1);
    cyc();
    check("t3_drained", count, 0);

    // T4 packet accounting
    drive(1, 10, 0, 0); cyc();
    drive(1, 11, 0, 0); cyc();
    drive(1, 12, 1, 0); cyc();
    check("t4_pkt_one", pkt_count, 1);
    drive(1, 20, 0, 0); cyc();
    check("t4_count4", count, 4);
    check("t4_pkt_still1", pkt_count, 1);
    drive(0, 0, 0, 1); cyc();
    check("t4_head11", m_data, 11);
    drive(1, 21, 1, 0); cyc();
    check("t4_pkt_two", pkt_count, 2);
    drive(0, 0, 0, 1); cyc();
    check("t4_head12_last", m_last, 1);
    cyc();
    check("t4_pkt_after_pop12", pkt_count, 1);
    check("t4_head20", m_data, 20);
    cyc();
    check("t4_head21_last", m_last, 1);
    drive(1, 30, 1, 1); cyc();
    check("t4_pkt_simul", pkt_count, 1);
    check("t4_count_simul", count, 1);
    check("t4_head30", m_data, 30);
    drive(0, 0, 0, 1); cyc();
    check("t4_pkt_zero", pkt_count, 0);

    // T5 flush
    drive(1, 40, 0, 0); cyc();
    drive(1, 41, 1, 0); cyc();
    drive(1, 42, 0, 0); cyc();
    check("t5_count3", count, 3);
    check("t5_pkt1", pkt_count, 1);
    flush = 1'b1;
    drive(1, 99, 1, 1);
    cyc();
    flush = 1'b0;
    drive(0, 0, 0, 0);
    check("t5_count0", count, 0);
    check("t5_pkt0", pkt_count, 0);
    check("t5_m_valid", m_valid, 0);
    check("t5_s_ready", s_ready, 1);
    cyc();
    check("t5_not_stored", count, 0);
    drive(1, 55, 0, 0); cyc();
    drive(0, 0, 0, 0);
    check("t5_after_flush", m_data, 55);
    drive(0, 0, 0, 1); cyc();
    check("t5_drained", count, 0);

    // T6 async reset while full
    for (int i = 0; i < 4; i++) begin
      drive(1, DW'(200 + i), 1, 0);
      cyc();
    end
    drive(0, 0, 0, 0);
    check("t6_full", count, 4);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_count", count, 0);
    check("t6_pkt", pkt_count, 0);
    check("t6_m_valid", m_valid, 0);
    check("t6_m_data", m_data, 0);
    check("t6_m_last", m_last, 0);
    check("t6_s_ready", s_ready, 0);
    #2;
    reset_n = 1'b1;
    cyc();
    check("t6_ready_back", s_ready, 1);

    // randomised scoreboard run
    random_run(400);
    drive(0, 0, 0, 1);
    repeat (D + 1) begin
      if (m_valid) check("drain_beat", {m_last, m_user, m_data}, exp_q.pop_front());
      cyc();
    end
    check("drain_count", count, 0);
    check("drain_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
